// File: rtl/unit_implication_queue.sv
// rtl/unit_implication_queue.sv - FIFO of unit implications with duplicate filtering and sticky conflict detection
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module unit_implication_queue #(
   parameter int DEPTH    = 8,
   parameter int VAR_BITS = `MAX_VARS_BITS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in_unit,
   input  logic [VAR_BITS-1:0]        in_var,
   input  logic                       in_val,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [VAR_BITS-1:0]        out_var,
   output logic                       out_val,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic                       conflict,
   output logic [VAR_BITS-1:0]        conflict_var,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [VAR_BITS-1:0] var_mem_q [DEPTH];
   logic [DEPTH-1:0]    val_mem_q;
   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                conflict_q, conflict_d;
   logic [VAR_BITS-1:0] conflict_var_q, conflict_var_d;
   logic                push_hs, pop, wr_en, match_same, match_opp;
   logic [PTR_W-1:0]    offset;

   assign in_ready     = (count_q != CNT_W'(DEPTH)) & ~conflict_q;
   assign out_valid    = (count_q != '0) & ~conflict_q;
   assign out_var      = (count_q != '0) ? var_mem_q[head_q] : '0;
   assign out_val      = (count_q != '0) & val_mem_q[head_q];
   assign conflict     = conflict_q;
   assign conflict_var = conflict_var_q;
   assign count        = count_q;

   assign push_hs = in_valid & in_ready & in_unit;
   assign pop     = out_valid & out_ready;
   assign wr_en   = push_hs & ~match_same & ~match_opp & ~flush;

   // An entry is live when its distance from head is below count; the head counts even if it pops now.
   always_comb begin
      match_same = 1'b0;
      match_opp  = 1'b0;
      offset     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - head_q;
         if (({1'b0, offset} < count_q) && (var_mem_q[i] == in_var)) begin
            if (val_mem_q[i] == in_val) match_same = 1'b1;
            else                        match_opp  = 1'b1;
         end
      end
   end

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      conflict_d     = conflict_q;
      conflict_var_d = conflict_var_q;
      if (flush) begin
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         conflict_d     = 1'b0;
         conflict_var_d = '0;
      end else begin
         if (push_hs & match_opp) begin
            conflict_d     = 1'b1;
            conflict_var_d = in_var;
         end
         if (wr_en) tail_d = tail_q + PTR_W'(1);
         if (pop)   head_d = head_q + PTR_W'(1);
         if (wr_en & ~pop)      count_d = count_q + CNT_W'(1);
         else if (pop & ~wr_en) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         var_mem_q[tail_q] <= in_var;
         val_mem_q[tail_q] <= in_val;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         conflict_q     <= 1'b0;
         conflict_var_q <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         conflict_q     <= conflict_d;
         conflict_var_q <= conflict_var_d;
      end
   end
endmodule

// File: doc/unit_implication_queue.md
UNIT_IMPLICATION_QUEUE -- requirements
Module: unit_implication_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of queue entries, power of two, at least 2.
REQ-002 SHALL have parameter VAR_BITS, default `MAX_VARS_BITS: width of a variable index.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the sub-clause evaluator result is present this cycle.
REQ-006 SHALL have port in_unit, input, 1: the evaluator's unit_clause flag.
REQ-007 SHALL have port in_var, input, VAR_BITS: the evaluator's implied_variable.
REQ-008 SHALL have port in_val, input, 1: the evaluator's new_val.
REQ-009 SHALL have port in_ready, output, 1: the queue can consider an implication this cycle.
REQ-010 SHALL have port out_valid, output, 1: the head implication is offered to the assignment stage.
REQ-011 SHALL have port out_var, output, VAR_BITS: variable index of the head entry.
REQ-012 SHALL have port out_val, output, 1: value of the head entry.
REQ-013 SHALL have port out_ready, input, 1: the assignment stage accepts the head this cycle.
REQ-014 SHALL have port flush, input, 1: synchronous clear, used on backtrack.
REQ-015 SHALL have port conflict, output, 1: sticky flag, set when two implications contradict.
REQ-016 SHALL have port conflict_var, output, VAR_BITS: variable that caused the conflict.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1: number of valid entries.

Function
REQ-018 SHALL drive in_ready = ~full & ~conflict, where full means count==DEPTH; there is no pass-through when full.
REQ-019 SHALL treat in_valid & in_ready as a handshake; if in_unit=0 in that cycle, the input is consumed with no state change.
REQ-020 SHALL compare each handshaked unit implication against every valid entry, including the head being popped in the same cycle.
REQ-021 SHALL discard a match on the same var with the same val (duplicate): no write, count unaffected by the push.
REQ-022 SHALL treat a match on the same var with the opposite val as a conflict: no write; conflict set to 1 and conflict_var set to in_var on the next edge.
REQ-023 SHALL otherwise write {in_var,in_val} at the tail; tail advances modulo DEPTH.
REQ-024 SHALL drive out_valid = (count!=0) & ~conflict; out_var and out_val equal the head entry, or 0 when count==0.
REQ-025 SHALL pop on out_valid & out_ready; head advances modulo DEPTH.
REQ-026 SHALL NOT bypass: a write in cycle N is first visible on the outputs in cycle N+1.
REQ-027 SHALL apply push and pop in the same cycle together: count unchanged; the head updates to the next entry, or to the new entry if it was the only one.
REQ-028 SHALL hold conflict and conflict_var until flush or reset; while conflict=1, no push or pop occurs.
REQ-029 SHALL make flush=1 take priority over push, pop and conflict detection; on the next edge, count=0, head=tail=0, conflict=0, conflict_var=0.
REQ-030 SHALL update count as +1 on a write without pop, -1 on a pop without write, else unchanged; it never exceeds DEPTH or goes below 0.
REQ-031 SHALL derive all outputs from registered state only: no combinational path from in_* to out_*; in_ready depends only on state.

Reset
REQ-032 SHALL respond to reset=1 immediately, independent of clock, with: count=0, head=tail=0, conflict=0, conflict_var=0, out_valid=0, out_var=0, out_val=0, in_ready=1.
REQ-033 SHALL make reset asserted mid-operation discard all entries; entry contents need not be cleared, but none may be visible.

Verification
REQ-034 SHALL be covered by: push (var 5,val 1), then (var 9,val 0), out_ready=1 -> out (5,1) in cycle 1, (9,0) in cycle 2, count returns to 0.
REQ-035 SHALL be covered by: push (5,1) twice with out_ready=0 -> count=1, conflict=0; then push (5,0) -> conflict=1, conflict_var=5, out_valid=0, in_ready=0.
REQ-036 SHALL be covered by: 8 unique pushes with DEPTH=8 and out_ready=0 -> count=8, in_ready=0; a 9th offer is not taken; 3 pops then 3 pushes -> tail wraps, FIFO order preserved.
REQ-037 SHALL be covered by: count=3, push (12,1) and pop in the same cycle -> count stays 3; (12,1) is emitted 3 pops later.
REQ-038 SHALL be covered by: conflict=1, assert flush together with in_valid and a unit implication -> next cycle count=0, conflict=0, input ignored; a later push works normally.
REQ-039 SHALL be covered by: reset asserted between clock edges while count=4 -> outputs go to their reset values before the next edge.
